// File: rtl/multicycle_control_unit_if.sv
// Handshake bundle between the multicycle control FSM and its datapath/memory.
// The datapath drives the decode fields, ALU flags and mem_ready; the FSM drives the strobes.
interface multicycle_control_unit_if #(
   parameter int CNT_W = 32
);
   logic [5:0]       opcode;
   logic [5:0]       func;
   logic             zero;
   logic             negative;
   logic             mem_ready;

   logic             ir_write;
   logic             pc_write;
   logic             mem_read;
   logic             mem_write_en;
   logic             mem_or_reg;
   logic             reg_write_enable;
   logic             reg_dest;
   logic             alu_src;
   logic             link;
   logic             branch;
   logic             jump;
   logic             jump_register;
   logic             does_shift_amount_need;
   logic             is_unsigned;
   logic             halted;
   logic             mem_error;
   logic [2:0]       state;
   logic [CNT_W-1:0] instr_count;

   modport master (
      output opcode, func, zero, negative, mem_ready,
      input  ir_write, pc_write, mem_read, mem_write_en, mem_or_reg, reg_write_enable,
             reg_dest, alu_src, link, branch, jump, jump_register, does_shift_amount_need,
             is_unsigned, halted, mem_error, state, instr_count
   );

   modport slave (
      input  opcode, func, zero, negative, mem_ready,
      output ir_write, pc_write, mem_read, mem_write_en, mem_or_reg, reg_write_enable,
             reg_dest, alu_src, link, branch, jump, jump_register, does_shift_amount_need,
             is_unsigned, halted, mem_error, state, instr_count
   );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS-subset control FSM: FETCH/DECODE/EXEC/MEM/WB/HALT with a memory-wait
// timeout, a sticky memory-error flag and a retired-instruction counter.
module multicycle_control_unit #(
   parameter int CNT_W       = 32,
   parameter int MEM_TIMEOUT = 15
) (
   input logic                      clk,
   input logic                      rst,
   multicycle_control_unit_if.slave bus
);
   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4,
      HALT   = 3'd5
   } state_t;

   localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

   state_t           state_q, state_d;
   logic [5:0]       op_q, fn_q;
   logic [7:0]       wait_q;
   logic             err_q;
   logic [CNT_W-1:0] cnt_q;

   // Decode of the latched instruction fields; EXEC onward never looks at the live inputs.
   logic r_type, i_alu, is_lw, is_sw, is_br, shift_op, unsigned_op, br_taken, timeout;

   assign r_type      = (op_q == 6'h00);
   assign i_alu       = (op_q[5:3] == 3'b001);
   assign is_lw       = (op_q == 6'h23);
   assign is_sw       = (op_q == 6'h2B);
   assign is_br       = (op_q[5:2] == 4'b0001);
   assign shift_op    = r_type && (fn_q == 6'h00 || fn_q == 6'h02 || fn_q == 6'h03);
   assign unsigned_op = (op_q == 6'h09) || (op_q == 6'h0B) ||
                        (r_type && (fn_q == 6'h21 || fn_q == 6'h23 || fn_q == 6'h2B));
   assign timeout     = !bus.mem_ready && (wait_q == TIMEOUT);

   always_comb begin
      br_taken = 1'b0;
      case (op_q[1:0])
         2'b00: br_taken = bus.zero;
         2'b01: br_taken = !bus.zero;
         2'b10: br_taken = bus.zero || bus.negative;
         2'b11: br_taken = !bus.zero && !bus.negative;
         default: br_taken = 1'b0;
      endcase
   end

   always_comb begin
      state_d                    = state_q;
      bus.ir_write               = 1'b0;
      bus.pc_write               = 1'b0;
      bus.mem_read               = 1'b0;
      bus.mem_write_en           = 1'b0;
      bus.mem_or_reg             = 1'b0;
      bus.reg_write_enable       = 1'b0;
      bus.reg_dest               = 1'b0;
      bus.alu_src                = 1'b0;
      bus.link                   = 1'b0;
      bus.branch                 = 1'b0;
      bus.jump                   = 1'b0;
      bus.jump_register          = 1'b0;
      bus.does_shift_amount_need = 1'b0;
      bus.is_unsigned            = 1'b0;
      case (state_q)
         FETCH: begin
            bus.mem_read = 1'b1;
            if (bus.mem_ready) begin
               bus.ir_write = 1'b1;
               state_d      = DECODE;
            end else if (timeout) begin
               state_d = HALT;
            end
         end
         DECODE: state_d = (bus.opcode == 6'h00 && bus.func == 6'h0C) ? HALT : EXEC;
         EXEC: begin
            bus.does_shift_amount_need = shift_op;
            bus.is_unsigned            = unsigned_op;
            state_d                    = FETCH;
            if (is_br) begin
               bus.branch   = br_taken;
               bus.pc_write = 1'b1;
            end else if (op_q == 6'h02) begin
               bus.jump     = 1'b1;
               bus.pc_write = 1'b1;
            end else if (op_q == 6'h03) begin
               bus.jump             = 1'b1;
               bus.link             = 1'b1;
               bus.reg_write_enable = 1'b1;
               bus.pc_write         = 1'b1;
            end else if (r_type && fn_q == 6'h08) begin
               bus.jump_register = 1'b1;
               bus.pc_write      = 1'b1;
            end else if (is_lw || is_sw) begin
               bus.alu_src = 1'b1;
               state_d     = MEM;
            end else if (r_type || i_alu) begin
               state_d = WB;
            end else begin
               bus.pc_write = 1'b1;
            end
         end
         MEM: begin
            bus.mem_read     = is_lw;
            bus.mem_write_en = !is_lw;
            if (bus.mem_ready) begin
               if (is_lw) begin
                  state_d = WB;
               end else begin
                  bus.pc_write = 1'b1;
                  state_d      = FETCH;
               end
            end else if (timeout) begin
               state_d = HALT;
            end
         end
         WB: begin
            bus.reg_write_enable       = 1'b1;
            bus.pc_write               = 1'b1;
            bus.reg_dest               = r_type;
            bus.alu_src                = i_alu;
            bus.mem_or_reg             = is_lw;
            bus.does_shift_amount_need = shift_op;
            bus.is_unsigned            = unsigned_op;
            state_d                    = FETCH;
         end
         HALT:    state_d = HALT;
         default: state_d = HALT;
      endcase
      // State is already FETCH during reset, but nothing may strobe until it is released.
      if (rst) begin
         bus.ir_write               = 1'b0;
         bus.pc_write               = 1'b0;
         bus.mem_read               = 1'b0;
         bus.mem_write_en           = 1'b0;
         bus.mem_or_reg             = 1'b0;
         bus.reg_write_enable       = 1'b0;
         bus.reg_dest               = 1'b0;
         bus.alu_src                = 1'b0;
         bus.link                   = 1'b0;
         bus.branch                 = 1'b0;
         bus.jump                   = 1'b0;
         bus.jump_register          = 1'b0;
         bus.does_shift_amount_need = 1'b0;
         bus.is_unsigned            = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= FETCH;
         op_q    <= '0;
         fn_q    <= '0;
         wait_q  <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == DECODE) begin
            op_q <= bus.opcode;
            fn_q <= bus.func;
         end
         // Any state change clears the wait count, so it is zero on entry to FETCH/MEM.
         if (state_d != state_q)
            wait_q <= '0;
         else if ((state_q == FETCH || state_q == MEM) && !bus.mem_ready)
            wait_q <= wait_q + 8'd1;
         if ((state_q == FETCH || state_q == MEM) && timeout)
            err_q <= 1'b1;
         if (bus.pc_write)
            cnt_q <= cnt_q + 1'b1;
      end
   end

   assign bus.state       = state_q;
   assign bus.halted      = !rst && (state_q == HALT);
   assign bus.mem_error   = err_q;
   assign bus.instr_count = cnt_q;
endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed table-driven bench for the multicycle control FSM (4-bit counter, timeout of 4),
// followed by hand sequences for wrap, SYSCALL halt, fetch timeout and mid-access reset.
module tb_multicycle_control_unit;
   localparam logic [15:0] IRW = 16'h8000, PCW = 16'h4000, MRD = 16'h2000, MWR = 16'h1000;
   localparam logic [15:0] MOR = 16'h0800, RWE = 16'h0400, RDS = 16'h0200, ASR = 16'h0100;
   localparam logic [15:0] LNK = 16'h0080, BR  = 16'h0040, JMP = 16'h0020, JRG = 16'h0010;
   localparam logic [15:0] SH  = 16'h0008, UNS = 16'h0004, HLT = 16'h0002, MER = 16'h0001;
   localparam logic [5:0]  G   = 6'h3F;

   typedef struct {
      logic [5:0]  op;
      logic [5:0]  fn;
      logic        z;
      logic        n;
      logic        rdy;
      logic [2:0]  st;
      logic [15:0] o;
      logic [3:0]  cnt;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   vec_t tbl[$];

   always #5 clk = ~clk;

   multicycle_control_unit_if #(.CNT_W(4)) bus ();

   multicycle_control_unit #(.CNT_W(4), .MEM_TIMEOUT(4)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   function automatic vec_t mk(input logic [5:0] op, input logic [5:0] fn, input logic z,
                               input logic n, input logic rdy, input logic [2:0] st,
                               input logic [15:0] o, input logic [3:0] cnt);
      vec_t v;
      v.op = op; v.fn = fn; v.z = z; v.n = n; v.rdy = rdy; v.st = st; v.o = o; v.cnt = cnt;
      return v;
   endfunction

   function automatic logic [15:0] outs();
      return {bus.ir_write, bus.pc_write, bus.mem_read, bus.mem_write_en, bus.mem_or_reg,
              bus.reg_write_enable, bus.reg_dest, bus.alu_src, bus.link, bus.branch, bus.jump,
              bus.jump_register, bus.does_shift_amount_need, bus.is_unsigned, bus.halted,
              bus.mem_error};
   endfunction

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic [2:0] st, input logic [15:0] o,
                            input logic [3:0] cnt);
      chk({tag, " state"}, 16'(bus.state), 16'(st));
      chk({tag, " outs"}, outs(), o);
      chk({tag, " count"}, 16'(bus.instr_count), 16'(cnt));
   endtask

   // One clock cycle: drive inputs just after the edge, compare at the falling edge.
   task automatic apply(input string tag, input vec_t v);
      bus.opcode = v.op; bus.func = v.fn; bus.zero = v.z; bus.negative = v.n;
      bus.mem_ready = v.rdy;
      @(negedge clk);
      check_all(tag, v.st, v.o, v.cnt);
      @(posedge clk);
      #1;
   endtask

   task automatic reset_pulse(input string tag);
      rst = 1'b1;
      #2;
      check_all(tag, 3'd0, 16'h0000, 4'd0);
      @(posedge clk);
      #1;
      check_all({tag, " held"}, 3'd0, 16'h0000, 4'd0);
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // ADDIU
      tbl.push_back(mk(G, G, 0, 0, 1, 0, IRW | MRD, 0));
      tbl.push_back(mk(6'h09, G, 0, 0, 1, 1, 0, 0));
      tbl.push_back(mk(G, G, 0, 0, 1, 2, UNS, 0));
      tbl.push_back(mk(G, G, 0, 0, 1, 4, RWE | PCW | ASR | UNS, 0));
      // BEQ taken, BNE not taken, BLEZ on negative, BGTZ on positive
      tbl.push_back(mk(G, G, 0, 0, 1, 0, IRW | MRD, 1));
      tbl.push_back(mk(6'h04, G, 0, 0, 1, 1, 0, 1));
      tbl.push_back(mk(G, G, 1, 0, 1, 2, BR | PCW, 1));
      tbl.push_back(mk(G, G, 0, 0, 1, 0, IRW | MRD, 2));
      tbl.push_back(mk(6'h05, G, 0, 0, 1, 1, 0, 2));
      tbl.push_back(mk(G, G, 1, 0, 1, 2, PCW, 2));
      tbl.push_back(mk(G, G, 0, 0, 1, 0, IRW | MRD, 3));
      tbl.push_back(mk(6'h06, G, 0, 0, 1, 1, 0, 3));
      tbl.push_back(mk(G, G, 0, 1, 1, 2, BR | PCW, 3));
      tbl.push_back(mk(G, G, 0, 0, 1, 0, IRW | MRD, 4));
      tbl.push_back(mk(6'h07, G, 0, 0, 1, 1, 0, 4));
      tbl.push_back(mk(G, G, 0, 0, 1, 2, BR | PCW, 4));
      // JAL, JR
      tbl.push_back(mk(G, G, 0, 0, 1, 0, IRW | MRD, 5));
      tbl.push_back(mk(6'h03, G, 0, 0, 1, 1, 0, 5));
      tbl.push_back(mk(G, G, 0, 0, 1, 2, JMP | LNK | RWE | PCW, 5));
      tbl.push_back(mk(G, G, 0, 0, 1, 0, IRW | MRD, 6));
      tbl.push_back(mk(6'h00, 6'h08, 0, 0, 1, 1, 0, 6));
      tbl.push_back(mk(G, G, 0, 0, 1, 2, JRG | PCW, 6));
      // SRA, ADDU
      tbl.push_back(mk(G, G, 0, 0, 1, 0, IRW | MRD, 7));
      tbl.push_back(mk(6'h00, 6'h03, 0, 0, 1, 1, 0, 7));
      tbl.push_back(mk(G, G, 0, 0, 1, 2, SH, 7));
      tbl.push_back(mk(G, G, 0, 0, 1, 4, RWE | PCW | RDS | SH, 7));
      tbl.push_back(mk(G, G, 0, 0, 1, 0, IRW | MRD, 8));
      tbl.push_back(mk(6'h00, 6'h21, 0, 0, 1, 1, 0, 8));
      tbl.push_back(mk(G, G, 0, 0, 1, 2, UNS, 8));
      tbl.push_back(mk(G, G, 0, 0, 1, 4, RWE | PCW | RDS | UNS, 8));
      // unrecognised opcode is a NOP
      tbl.push_back(mk(G, G, 0, 0, 1, 0, IRW | MRD, 9));
      tbl.push_back(mk(G, G, 0, 0, 1, 1, 0, 9));
      tbl.push_back(mk(G, G, 0, 0, 1, 2, PCW, 9));
      // LW with three wait cycles
      tbl.push_back(mk(G, G, 0, 0, 1, 0, IRW | MRD, 10));
      tbl.push_back(mk(6'h23, G, 0, 0, 1, 1, 0, 10));
      tbl.push_back(mk(G, G, 0, 0, 1, 2, ASR, 10));
      tbl.push_back(mk(G, G, 0, 0, 0, 3, MRD, 10));
      tbl.push_back(mk(G, G, 0, 0, 0, 3, MRD, 10));
      tbl.push_back(mk(G, G, 0, 0, 0, 3, MRD, 10));
      tbl.push_back(mk(G, G, 0, 0, 1, 3, MRD, 10));
      tbl.push_back(mk(G, G, 0, 0, 1, 4, RWE | PCW | MOR, 10));
      // SW with three wait cycles
      tbl.push_back(mk(G, G, 0, 0, 1, 0, IRW | MRD, 11));
      tbl.push_back(mk(6'h2B, G, 0, 0, 1, 1, 0, 11));
      tbl.push_back(mk(G, G, 0, 0, 1, 2, ASR, 11));
      tbl.push_back(mk(G, G, 0, 0, 0, 3, MWR, 11));
      tbl.push_back(mk(G, G, 0, 0, 0, 3, MWR, 11));
      tbl.push_back(mk(G, G, 0, 0, 0, 3, MWR, 11));
      tbl.push_back(mk(G, G, 0, 0, 1, 3, MWR | PCW, 11));
      // J, then a fetch that is ready on its last legal cycle
      tbl.push_back(mk(G, G, 0, 0, 1, 0, IRW | MRD, 12));
      tbl.push_back(mk(6'h02, G, 0, 0, 1, 1, 0, 12));
      tbl.push_back(mk(G, G, 0, 0, 1, 2, JMP | PCW, 12));
      for (int i = 0; i < 4; i++) tbl.push_back(mk(G, G, 0, 0, 0, 0, MRD, 13));
      tbl.push_back(mk(G, G, 0, 0, 1, 0, IRW | MRD, 13));
      // all-zero word is SLL, not SYSCALL
      tbl.push_back(mk(6'h00, 6'h00, 0, 0, 1, 1, 0, 13));
      tbl.push_back(mk(G, G, 0, 0, 1, 2, SH, 13));
      tbl.push_back(mk(G, G, 0, 0, 1, 4, RWE | PCW | RDS | SH, 13));
      tbl.push_back(mk(G, G, 0, 0, 1, 0, IRW | MRD, 14));

      rst = 1'b1;
      bus.opcode = '0; bus.func = '0; bus.zero = 1'b0; bus.negative = 1'b0; bus.mem_ready = 1'b0;
      @(posedge clk);
      #1;
      check_all("reset", 3'd0, 16'h0000, 4'd0);
      rst = 1'b0;

      foreach (tbl[i]) apply($sformatf("row%0d", i), tbl[i]);

      // Three NOPs take the count 14 -> 15 -> 0 -> 1 (17 retired).
      for (int k = 0; k < 3; k++) begin
         apply($sformatf("nop%0d dec", k), mk(G, G, 0, 0, 1, 1, 0, 4'(14 + k)));
         apply($sformatf("nop%0d exe", k), mk(G, G, 0, 0, 1, 2, PCW, 4'(14 + k)));
         apply($sformatf("nop%0d fet", k), mk(G, G, 0, 0, 1, 0, IRW | MRD, 4'(15 + k)));
      end

      // SYSCALL halts straight from DECODE without retiring.
      apply("syscall dec", mk(6'h00, 6'h0C, 0, 0, 1, 1, 0, 1));
      apply("halt0", mk(G, G, 0, 0, 1, 5, HLT, 1));
      apply("halt1", mk(6'h23, G, 1, 0, 0, 5, HLT, 1));
      reset_pulse("rst from halt");

      // Fetch never ready: five FETCH cycles, then HALT with sticky mem_error.
      for (int k = 0; k < 5; k++) apply($sformatf("tmo%0d", k), mk(G, G, 0, 0, 0, 0, MRD, 0));
      apply("tmo halt", mk(G, G, 0, 0, 0, 5, HLT | MER, 0));
      apply("tmo halt rdy", mk(G, G, 0, 0, 1, 5, HLT | MER, 0));
      reset_pulse("rst clears err");

      // Reset in the middle of an LW access.
      apply("lw2 fet", mk(G, G, 0, 0, 1, 0, IRW | MRD, 0));
      apply("lw2 dec", mk(6'h23, G, 0, 0, 1, 1, 0, 0));
      apply("lw2 exe", mk(G, G, 0, 0, 1, 2, ASR, 0));
      apply("lw2 mem", mk(G, G, 0, 0, 0, 3, MRD, 0));
      reset_pulse("rst mid mem");
      apply("post rst fet", mk(G, G, 0, 0, 1, 0, IRW | MRD, 0));
      apply("post rst dec", mk(6'h09, G, 0, 0, 1, 1, 0, 0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
